// File: rtl/audio_level_meter_if.sv
// rtl/audio_level_meter_if.sv - read-side FIFO port bundle between the sample FIFO and the level meter
interface audio_level_meter_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] q;
  logic              rdempty;
  logic              rdfull;
  logic              rdreq;

  // master is the FIFO consumer (the meter); slave is the FIFO read port
  modport master (
    input  q,
    input  rdempty,
    input  rdfull,
    output rdreq
  );

  modport slave (
    output q,
    output rdempty,
    output rdfull,
    input  rdreq
  );
endinterface

// File: rtl/audio_level_meter.sv
// rtl/audio_level_meter.sv - windowed peak/mean amplitude meter popping the audio sample FIFO
// Optional macro AUDIO_LEVEL_PEAK_HOLD_EN turns level_peak into a decaying peak hold.
module audio_level_meter #(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  audio_level_meter_if.master  fifo,
  input  logic                 overrun_clr,
  output logic [DATA_W-2:0]    level_peak,
  output logic [DATA_W-2:0]    level_avg,
  output logic                 level_valid,
  output logic                 overrun
);

  localparam int MAG_W = DATA_W - 1;
  localparam int SUM_W = MAG_W + WIN_LOG2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACCUM   = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                rdreq_q, rdreq_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [MAG_W-1:0]    peak_q, peak_d;
  logic [WIN_LOG2-1:0] count_q, count_d;
  logic [MAG_W-1:0]    level_peak_q, level_peak_d;
  logic [MAG_W-1:0]    level_avg_q, level_avg_d;
  logic                level_valid_q, level_valid_d;
  logic                overrun_q, overrun_d;

  logic [DATA_W-1:0]   neg_q;
  logic [MAG_W-1:0]    mag;
  logic [MAG_W-1:0]    pub_peak;

  // The most negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    neg_q = DATA_W'(0) - fifo.q;
    if (!fifo.q[DATA_W-1]) begin
      mag = fifo.q[MAG_W-1:0];
    end else if (fifo.q[MAG_W-1:0] == '0) begin
      mag = '1;
    end else begin
      mag = neg_q[MAG_W-1:0];
    end
  end

`ifdef AUDIO_LEVEL_PEAK_HOLD_EN
  logic [MAG_W-1:0] held_dec;

  always_comb begin
    held_dec = level_peak_q - (level_peak_q >> 4);
    if (peak_q >= level_peak_q) begin
      pub_peak = peak_q;
    end else if (held_dec < peak_q) begin
      pub_peak = peak_q;
    end else begin
      pub_peak = held_dec;
    end
  end
`else
  always_comb begin
    pub_peak = peak_q;
  end
`endif

  always_comb begin
    state_d       = state_q;
    rdreq_d       = 1'b0;
    sum_d         = sum_q;
    peak_d        = peak_q;
    count_d       = count_q;
    level_peak_d  = level_peak_q;
    level_avg_d   = level_avg_q;
    level_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo.rdempty) begin
          rdreq_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = ACCUM;
      end
      ACCUM: begin
        sum_d   = sum_q + SUM_W'(mag);
        peak_d  = (mag > peak_q) ? mag : peak_q;
        count_d = count_q + WIN_LOG2'(1);
        if (count_q == {WIN_LOG2{1'b1}}) begin
          state_d = PUBLISH;
        end else begin
          state_d = IDLE;
        end
      end
      PUBLISH: begin
        level_peak_d  = pub_peak;
        level_avg_d   = sum_q[SUM_W-1:WIN_LOG2];
        level_valid_d = 1'b1;
        sum_d         = '0;
        peak_d        = '0;
        count_d       = '0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A full FIFO in the same cycle as a clear keeps the flag set.
  always_comb begin
    if (fifo.rdfull) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      rdreq_q       <= 1'b0;
      sum_q         <= '0;
      peak_q        <= '0;
      count_q       <= '0;
      level_peak_q  <= '0;
      level_avg_q   <= '0;
      level_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdreq_q       <= rdreq_d;
      sum_q         <= sum_d;
      peak_q        <= peak_d;
      count_q       <= count_d;
      level_peak_q  <= level_peak_d;
      level_avg_q   <= level_avg_d;
      level_valid_q <= level_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign fifo.rdreq  = rdreq_q;
  assign level_peak  = level_peak_q;
  assign level_avg   = level_avg_q;
  assign level_valid = level_valid_q;
  assign overrun     = overrun_q;

endmodule
